// File: rtl/md_pkg.sv
// md_pkg: shared types and default latencies for the multiply/divide issue controller.
package md_pkg;
   typedef enum logic [2:0] {NONE = 3'd0, MULT, MULTU, DIV, DIVU, MTHI, MTLO} md_op_e;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} md_state_e;
   localparam int MD_MULT_LAT = 5;
   localparam int MD_DIV_LAT  = 10;
endpackage

// File: rtl/md_lat_cnt.sv
// md_lat_cnt: loadable 4-bit down-counter that holds at zero.
module md_lat_cnt (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       en,
   output logic [3:0] val,
   output logic       zero
);
   always_ff @(posedge clk)
      if (reset) val <= '0;
      else if (load) val <= load_val;
      else if (en && !zero) val <= val - 4'd1;
   assign zero = val == 4'd0;
endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: decodes E-stage MD ops into unit controls and stalls D for the unit's fixed latency.
// Optional MD_CTRL_STALL_CNT_EN adds a saturating stall_cycles counter output.
module md_issue_ctrl
   import md_pkg::*;
#(
   parameter int MULT_LAT = MD_MULT_LAT,
   parameter int DIV_LAT  = MD_DIV_LAT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       e_valid,
   input  logic [2:0] e_md_op,
   input  logic       e_flush,
   input  logic       d_md_use,
   input  logic       md_busy,
   output logic       md_start,
   output logic [1:0] md_op,
   output logic       md_sign,
   output logic       md_we,
   output logic       md_write_sel,
   output logic       stall_d,
   output logic       ctrl_busy,
   output logic       proto_err
`ifdef MD_CTRL_STALL_CNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);
   md_state_e  state, state_nxt;
   md_op_e     op;
   logic       idle, is_div, issue, viol, cnt_zero;
   logic [3:0] cnt, cnt_ld;
   md_lat_cnt u_cnt (
      .clk(clk), .reset(reset), .load(issue), .load_val(cnt_ld),
      .en(!idle), .val(cnt), .zero(cnt_zero)
   );
   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_nxt;
   // Any MD op arriving while the unit is occupied is dropped and flagged.
   always_comb begin
      op           = md_op_e'(e_md_op);
      idle         = state == IDLE;
      is_div       = op == DIV || op == DIVU;
      viol         = e_valid && op != NONE && (!idle || md_busy);
      issue        = e_valid && !e_flush && idle && !md_busy && op inside {MULT, MULTU, DIV, DIVU};
      cnt_ld       = is_div ? 4'(DIV_LAT - 1) : 4'(MULT_LAT - 1);
      md_start     = issue;
      md_op        = {1'b0, is_div};
      md_sign      = op == MULT || op == DIV;
      md_we        = e_valid && !e_flush && idle && !md_busy && (op == MTHI || op == MTLO);
      md_write_sel = op == MTLO;
      stall_d      = d_md_use && (issue || !idle || md_busy);
      ctrl_busy    = !idle;
      state_nxt    = issue ? RUN : (!idle && cnt_zero) ? IDLE : state;
   end
   always_ff @(posedge clk)
      if (reset) proto_err <= 1'b0;
      else if (viol) proto_err <= 1'b1;
`ifdef MD_CTRL_STALL_CNT_EN
   always_ff @(posedge clk)
      if (reset) stall_cycles <= '0;
      else if (stall_d && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
`endif
endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: scoreboard bench for md_issue_ctrl driven from an independent cycle model.
module tb_md_issue_ctrl;
   import md_pkg::*;
   logic       clk = 1'b0;
   logic       reset, e_valid, e_flush, d_md_use, md_busy;
   logic [2:0] e_md_op;
   logic       md_start, md_sign, md_we, md_write_sel, stall_d, ctrl_busy, proto_err;
   logic [1:0] md_op;
`ifdef MD_CTRL_STALL_CNT_EN
   logic [31:0] stall_cycles;
`endif
   typedef struct {
      string       tag;
      logic [8:0]  exp;
      logic [31:0] sc;
   } item_t;
   item_t       sb[$];
   int          checks = 0, errors = 0;
   int          m_rem = 0;
   bit          m_perr = 1'b0;
   logic [31:0] m_sc = '0;
   md_issue_ctrl dut (
      .clk(clk), .reset(reset), .e_valid(e_valid), .e_md_op(e_md_op), .e_flush(e_flush),
      .d_md_use(d_md_use), .md_busy(md_busy), .md_start(md_start), .md_op(md_op),
      .md_sign(md_sign), .md_we(md_we), .md_write_sel(md_write_sel), .stall_d(stall_d),
      .ctrl_busy(ctrl_busy), .proto_err(proto_err)
`ifdef MD_CTRL_STALL_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );
   always #5 clk = ~clk;
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   always @(negedge clk)
      if (sb.size() > 0) begin
         item_t it;
         it = sb.pop_front();
         check(it.tag, 32'({md_start, md_op, md_sign, md_we, md_write_sel, stall_d, ctrl_busy, proto_err}),
               32'(it.exp));
`ifdef MD_CTRL_STALL_CNT_EN
         check({it.tag, "_sc"}, stall_cycles, it.sc);
`endif
      end
   // One clock cycle of stimulus; rst cycles are not checked and clear the model.
   task automatic step(string tag, bit rst, bit v, logic [2:0] op, bit fl, bit du, bit b);
      bit    idle, mdop, iss, we, viol, st;
      item_t it;
      @(posedge clk);
      #1;
      reset = rst; e_valid = v; e_md_op = op; e_flush = fl; d_md_use = du; md_busy = b;
      if (rst) begin
         m_rem = 0; m_perr = 1'b0; m_sc = '0;
      end else begin
         idle   = m_rem == 0;
         mdop   = op inside {3'd1, 3'd2, 3'd3, 3'd4};
         iss    = v && !fl && idle && !b && mdop;
         we     = v && !fl && idle && !b && (op == 3'd5 || op == 3'd6);
         viol   = v && op != 3'd0 && (!idle || b);
         st     = du && (iss || !idle || b);
         it.tag = tag;
         it.exp = {iss, 1'b0, op == 3'd3 || op == 3'd4, op == 3'd1 || op == 3'd3, we, op == 3'd6, st, !idle, m_perr};
         it.sc  = m_sc;
         sb.push_back(it);
         if (iss) m_rem = (op >= 3'd3) ? MD_DIV_LAT : MD_MULT_LAT;
         else if (m_rem > 0) m_rem--;
         m_perr = m_perr | viol;
         if (st && m_sc != '1) m_sc++;
      end
   endtask
   initial begin
      reset = 1'b1; e_valid = 1'b0; e_md_op = '0; e_flush = 1'b0; d_md_use = 1'b0; md_busy = 1'b0;
      step("rst", 1, 0, NONE, 0, 0, 0);
      step("rst", 1, 0, NONE, 0, 0, 0);
      step("reset_state", 0, 0, NONE, 0, 0, 0);
      step("idle_duse", 0, 0, NONE, 0, 1, 0);
      step("mult_issue", 0, 1, MULT, 0, 1, 0);
      repeat (6) step("mult_run", 0, 0, NONE, 0, 1, m_rem != 0);
      step("divu_issue", 0, 1, DIVU, 0, 1, 0);
      repeat (11) step("divu_run", 0, 0, NONE, 0, 1, m_rem != 0);
      step("div_flush", 0, 1, DIV, 1, 1, 0);
      step("after_flush", 0, 0, NONE, 0, 1, 0);
      step("mtlo", 0, 1, MTLO, 0, 0, 0);
      step("mthi", 0, 1, MTHI, 0, 1, 0);
      step("valid_none", 0, 1, NONE, 0, 1, 0);
      step("mtlo_flush", 0, 1, MTLO, 1, 0, 0);
      step("div_issue", 0, 1, DIV, 0, 1, 0);
      repeat (2) step("div_run", 0, 0, NONE, 0, 1, m_rem != 0);
      step("rst", 1, 0, NONE, 0, 1, 0);
      step("post_reset", 0, 0, NONE, 0, 1, 0);
      step("multu_issue", 0, 1, MULTU, 0, 0, 0);
      step("multu_in_run", 0, 1, MULTU, 0, 1, 1);
      repeat (5) step("perr_run", 0, 0, NONE, 0, 1, m_rem != 0);
      step("perr_sticky", 0, 0, NONE, 0, 0, 0);
      step("mthi_busy", 0, 1, MTHI, 0, 1, 1);
      step("mult_busy", 0, 1, MULT, 0, 1, 1);
      step("idle_after", 0, 0, NONE, 0, 0, 0);
      repeat (80)
         step("rand", 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 6)),
              $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), m_rem != 0);
      @(negedge clk);
      #1;
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
